game_state_fsm: RTL
===================

# game_state_fsm

Top-level game controller for the flappy bird design. It turns the player button and game-logic events into the 2-bit screen state consumed by the menu/RGB multiplexer: 00 start screen, 01 game, 10 game over. It also owns the score and best-score registers and issues a one-cycle game-init pulse that restarts the bird/pipe logic. It sits between the input/game-logic blocks and the display mux, in the pixel clock domain.

## Interface
Parameters:
- HOLD_FRAMES, 60: frames during which presses are ignored after entering GAMEOVER; 0 = no hold.
- SCORE_W, 10: width of score and best registers.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- btn  in  1  raw player button level, asynchronous to clk.
- collision  in  1  level or pulse from game logic; bird hit pipe/ground.
- pipe_passed  in  1  one-cycle pulse per pipe cleared.
- state  out  2  ST_START / ST_GAME / ST_GAMEOVER encoding above; registered.
- game_init  out  1  one-cycle pulse on START->GAME.
- score  out  SCORE_W  current score; registered.
- best  out  SCORE_W  best score since reset; registered.
- new_best  out  1  level; high in GAMEOVER when the last game set a new best.

## Operation
- btn passes through a 2-flop synchroniser, then rising-edge detection: press = sync2 & ~sync2_d. One press per rising edge; holding btn gives no repeats.
- ST_START: press -> ST_GAME; score cleared to 0; game_init asserted. Other inputs ignored.
- ST_GAME: pipe_passed -> score+1, saturating at 2^SCORE_W-1. collision high in any cycle -> ST_GAMEOVER. On that transition, if score > best then best <= score and new_best <= 1. press ignored here (flap handled elsewhere).
- Simultaneous collision and pipe_passed: collision wins; the increment is dropped; the best comparison uses the pre-increment score.
- ST_GAMEOVER: on entry, hold counter loads HOLD_FRAMES. It decrements on each frame_tick until 0. A press while hold != 0 is discarded. A press with hold == 0 -> ST_START and clears new_best. score is retained for display until the next START->GAME.
- Encoding 2'b11 is illegal; if reached, next state is ST_START with no other register change.
- Reset (async assert, sync release by the system): state=ST_START, score=0, best=0, new_best=0, game_init=0, hold=0, synchroniser/edge flops=0. Reset mid-game discards best.

## Timing
- btn rising before edge k: sync1 at k, sync2 at k+1, press combinational in cycle after k+1, state/score/game_init updated at edge k+2.
- game_init is high for exactly the first cycle in which state==ST_GAME. It never asserts in any other state.
- pipe_passed sampled at edge n -> score visible after edge n.
- collision sampled at edge n -> state, best and new_best all updated at edge n.
- Hold: with HOLD_FRAMES=H, the earliest accepted press occurs after the H-th frame_tick following entry. A frame_tick coinciding with the entry edge does not count.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- game_pkg: typedef enum logic [1:0] state_t {ST_START=2'b00, ST_GAME=2'b01, ST_GAMEOVER=2'b10}; shared with the display mux and game logic.
- Sub-module btn_edge: synchroniser plus rising-edge pulse, with the same clk/rst. It is reusable for other buttons.
- Hold counter width is $clog2(HOLD_FRAMES+1), minimum 1.

## Test plan
- Reset, then btn high: state 00 until edge k+2; then state 01, game_init high one cycle, score 0.
- In GAME: 5 pipe_passed pulses, then collision -> score 5, best 5, new_best 1, state 10. Next game with score 3 -> best stays 5, new_best 0.
- HOLD_FRAMES=4: press after 2 frame_ticks is ignored, state stays 10. Press after the 4th tick -> state 00, new_best 0, score still shown.
- SCORE_W=3: 9 pipe_passed pulses -> score saturates at 7. collision and pipe_passed in the same cycle at score 2 -> score 2, state 10.
- btn held high across START->GAME->GAMEOVER->hold expiry: no second transition without a new rising edge.
- Reset asserted mid-GAME with score 4: all outputs zero/ST_START immediately; forced state 11 -> 00 next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Purpose: shared screen-state encoding for the game controller, display mux and game logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

    typedef enum logic [1:0] {
        ST_START    = 2'b00,
        ST_GAME     = 2'b01,
        ST_GAMEOVER = 2'b10
    } state_t;

    // Width of a down-counter that must hold the value n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/game_state_fsm_btn_edge.sv
// Purpose: two-flop synchroniser for an asynchronous button plus a rising-edge pulse.
// Latency: press is high in the cycle after sync2 first captures a rising level (edge k+2 consumer).
// Backpressure: none; one press pulse per rising edge, a held level never repeats.
//
// Ports: clk, rst (async active-low), btn (raw level), press (one-cycle pulse).
module game_state_fsm_btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sync2_dly_q, sync2_dly_d;

    always_comb begin
        sync1_d     = btn;
        sync2_d     = sync1_q;
        sync2_dly_d = sync2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync2_dly_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync2_dly_q <= sync2_dly_d;
        end
    end

    assign press = sync2_q & ~sync2_dly_q;

endmodule

// File: rtl/game_state_fsm.sv
// Purpose: flappy-bird top controller: screen state, score/best registers, game-init pulse.
// Latency: collision/pipe_passed act at the sampling edge; button press acts two edges after sync1.
// Backpressure: none; presses during the game-over hold window are discarded.
//
// Ports: clk, rst (async active-low), frame_tick, btn, collision, pipe_passed in;
//        state, game_init, score, best, new_best out (all registered).
module game_state_fsm
    import game_pkg::*;
#(
    parameter int HOLD_FRAMES = 60,
    parameter int SCORE_W     = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               btn,
    input  logic               collision,
    input  logic               pipe_passed,
    output logic [1:0]         state,
    output logic               game_init,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] best,
    output logic               new_best
);

    localparam int HOLD_W = cnt_width(HOLD_FRAMES);

    localparam logic [1:0] S_START    = ST_START;
    localparam logic [1:0] S_GAME     = ST_GAME;
    localparam logic [1:0] S_GAMEOVER = ST_GAMEOVER;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic press;

    // State is a plain 2-bit vector so the unused 2'b11 code stays representable and recoverable.
    logic [1:0]         state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] best_q, best_d;
    logic               new_best_q, new_best_d;
    logic               game_init_q, game_init_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;

    game_state_fsm_btn_edge u_btn_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .press (press)
    );

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        best_d      = best_q;
        new_best_d  = new_best_q;
        game_init_d = 1'b0;
        hold_d      = hold_q;

        case (state_q)
            S_START: begin
                if (press) begin
                    state_d     = S_GAME;
                    score_d     = '0;
                    game_init_d = 1'b1;
                end
            end

            S_GAME: begin
                // Collision takes priority: a same-cycle pipe_passed is dropped and the
                // best comparison sees the pre-increment score.
                if (collision) begin
                    state_d    = S_GAMEOVER;
                    hold_d     = HOLD_LOAD;
                    new_best_d = (score_q > best_q);
                    if (score_q > best_q) begin
                        best_d = score_q;
                    end
                end else if (pipe_passed && (score_q != SCORE_MAX)) begin
                    score_d = score_q + 1'b1;
                end
            end

            S_GAMEOVER: begin
                if (frame_tick && (hold_q != '0)) begin
                    hold_d = hold_q - 1'b1;
                end
                if (press && (hold_q == '0)) begin
                    state_d    = S_START;
                    new_best_d = 1'b0;
                end
            end

            default: begin
                // Unreachable code: return to the start screen, touch nothing else.
                state_d = S_START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_START;
            score_q     <= '0;
            best_q      <= '0;
            new_best_q  <= 1'b0;
            game_init_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            best_q      <= best_d;
            new_best_q  <= new_best_d;
            game_init_q <= game_init_d;
            hold_q      <= hold_d;
        end
    end

    assign state     = state_q;
    assign game_init = game_init_q;
    assign score     = score_q;
    assign best      = best_q;
    assign new_best  = new_best_q;

endmodule
